// File: rtl/bbox_byte_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : bbox_byte_serializer_if
// Description : Bundle of the box input handshake and the serialized byte
//               output handshake used by bbox_byte_serializer.
//               master : box producer / byte consumer side
//               slave  : the serializer itself
// Signals     : valid_in/ready_out     box handshake
//               min_*/max_* [15:0]     s7.8 box fields
//               byte_out/valid/ready   byte handshake, byte_last on byte 11
//               busy, box_count        status
// Revision    : 1.0 - initial release
// ============================================================================
interface bbox_byte_serializer_if;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] min_x;
   logic [15:0] min_y;
   logic [15:0] min_z;
   logic [15:0] max_x;
   logic [15:0] max_y;
   logic [15:0] max_z;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;
   logic        busy;
   logic [15:0] box_count;

   modport master (
      output valid_in, min_x, min_y, min_z, max_x, max_y, max_z, byte_ready,
      input  ready_out, byte_out, byte_valid, byte_last, busy, box_count
   );

   modport slave (
      input  valid_in, min_x, min_y, min_z, max_x, max_y, max_z, byte_ready,
      output ready_out, byte_out, byte_valid, byte_last, busy, box_count
   );
endinterface
`default_nettype wire

// File: rtl/bbox_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bbox_byte_serializer
// Description : Queues bounding boxes (six s7.8 fields) in a DEPTH-entry FIFO
//               and streams each one as a 12-byte little-endian record
//               (min_x, min_y, min_z, max_x, max_y, max_z; low byte first).
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               bus        bbox_byte_serializer_if.slave (box in, bytes out,
//                          busy and completed-box counter)
// Parameters  : DEPTH      FIFO depth in boxes: 2, 4, 8 or 16
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_byte_serializer #(
   parameter int DEPTH = 4
) (
   input wire                    clk,
   input wire                    rst,
   bbox_byte_serializer_if.slave bus
);

   localparam int         c_AW       = $clog2(DEPTH);
   localparam logic [0:0] c_IDLE     = 1'b0;
   localparam logic [0:0] c_SEND     = 1'b1;
   localparam logic [3:0] c_LAST_IDX = 4'd11;

   logic [95:0]     r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_occ;
   logic [0:0]      r_state;
   logic [3:0]      r_idx;
   logic [95:0]     r_hold;
   logic [15:0]     r_box_count;
   logic            r_run;

   logic            w_ready;
   logic            w_not_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_hs;
   logic            w_last_hs;
   logic [95:0]     w_entry;

   // Byte i of the record sits at bits [8i+7:8i], so the transmit mux is a
   // plain part-select on the holding register.
   assign w_entry = {bus.max_z, bus.max_y, bus.max_x,
                     bus.min_z, bus.min_y, bus.min_x};

   // DEPTH is a power of two, so occupancy == DEPTH exactly when the top
   // occupancy bit is set. r_run keeps ready_out low until one edge after
   // reset is released.
   assign w_ready     = r_run & ~r_occ[c_AW];
   assign w_not_empty = (r_occ != '0);
   assign w_push      = bus.valid_in & w_ready;
   assign w_hs        = (r_state == c_SEND) & bus.byte_ready;
   assign w_last_hs   = w_hs & (r_idx == c_LAST_IDX);
   // Only entries already present before this edge may be popped; a push in
   // the same cycle is never visible to the serializer until the next edge.
   assign w_pop       = w_not_empty & ((r_state == c_IDLE) | w_last_hs);

   // Storage carries no reset: validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occ       <= '0;
         r_state     <= c_IDLE;
         r_idx       <= 4'd0;
         r_hold      <= '0;
         r_box_count <= 16'd0;
         r_run       <= 1'b0;
      end else begin
         r_run <= 1'b1;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_occ <= r_occ + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};

         if (w_last_hs) begin
            r_box_count <= r_box_count + 16'd1;
         end

         // A pop on the final handshake reloads the holding register without
         // leaving SEND, giving a gap-free stream between boxes.
         if (w_pop) begin
            r_hold  <= r_mem[r_rd_ptr];
            r_idx   <= 4'd0;
            r_state <= c_SEND;
         end else if (w_last_hs) begin
            r_idx   <= 4'd0;
            r_state <= c_IDLE;
         end else if (w_hs) begin
            r_idx   <= r_idx + 4'd1;
         end
      end
   end

   assign bus.ready_out  = w_ready;
   assign bus.byte_valid = (r_state == c_SEND);
   assign bus.byte_out   = r_hold[{r_idx, 3'b000} +: 8];
   assign bus.byte_last  = (r_state == c_SEND) & (r_idx == c_LAST_IDX);
   assign bus.busy       = (r_state == c_SEND) | w_not_empty;
   assign bus.box_count  = r_box_count;

endmodule
`default_nettype wire

// File: tb/tb_bbox_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bbox_byte_serializer
// Description : Self-checking bench for bbox_byte_serializer. A cycle-level
//               reference model (box queue + current 12-byte record) tracks
//               the expected outputs; directed vectors and sequences cover
//               latency, back-to-back, backpressure, full FIFO and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bbox_byte_serializer;

   localparam int DEPTH = 4;

   typedef logic [11:0][7:0] rec_t;

   typedef struct {
      logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
      logic [95:0] exp_bytes;   // byte i at [8i+7:8i]
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bbox_byte_serializer_if bif ();

   bbox_byte_serializer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   // ---------------- reference model state ----------------
   rec_t        fifo_q [$];
   logic [7:0]  stream_q [$];
   logic [8:0]  got_q [$];
   rec_t        m_cur;
   bit          m_send, m_run, m_init;
   int          m_pos;
   logic [15:0] m_count;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_acc, run_len, max_run;
   bit bp_mode;
   bit prev_stall;
   logic [7:0] prev_byte;
   logic prev_last;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t make_rec(input logic [15:0] a, b, c, d, e, g);
      logic [15:0] f [6];
      rec_t r;
      f[0] = a; f[1] = b; f[2] = c; f[3] = d; f[4] = e; f[5] = g;
      for (int k = 0; k < 6; k++) begin
         r[2*k]   = 8'(f[k] % 256);
         r[2*k+1] = 8'(f[k] / 256);
      end
      return r;
   endfunction

   // Check outputs against the model, then advance the model by the edge
   // that follows (inputs are stable at the falling edge).
   always @(negedge clk) begin
      rec_t r;
      int   old_size;
      bit   acc, hs;
      if (m_init) begin
         chk("byte_valid", bif.byte_valid, m_send);
         if (m_send) chk("byte_out", bif.byte_out, m_cur[m_pos]);
         chk("byte_last", bif.byte_last, m_send && (m_pos == 11));
         chk("busy", bif.busy, m_send || (fifo_q.size() != 0));
         chk("ready_out", bif.ready_out, m_run && (fifo_q.size() < DEPTH));
         chk("box_count", bif.box_count, m_count);
         if (prev_stall) begin
            chk("stall_hold_byte", bif.byte_out, prev_byte);
            chk("stall_hold_last", bif.byte_last, prev_last);
         end
      end
      if (bif.byte_valid === 1'b1) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
      prev_stall = !rst && bif.byte_valid && !bif.byte_ready;
      prev_byte  = bif.byte_out;
      prev_last  = bif.byte_last;

      if (rst) begin
         fifo_q.delete();
         stream_q.delete();
         got_q.delete();
         m_send  = 0;
         m_pos   = 0;
         m_count = 16'd0;
         m_run   = 0;
         m_init  = 1;
      end else if (m_init) begin
         acc      = bif.valid_in && m_run && (fifo_q.size() < DEPTH);
         hs       = m_send && bif.byte_ready;
         old_size = fifo_q.size();
         if (bif.valid_in && bif.ready_out) dut_acc++;
         if (hs) got_q.push_back({bif.byte_last, bif.byte_out});
         if (!m_send) begin
            if (old_size > 0) begin
               m_cur  = fifo_q.pop_front();
               m_send = 1;
               m_pos  = 0;
            end
         end else if (hs) begin
            if (m_pos == 11) begin
               m_count = m_count + 16'd1;
               if (old_size > 0) begin
                  m_cur = fifo_q.pop_front();
                  m_pos = 0;
               end else begin
                  m_send = 0;
               end
            end else begin
               m_pos++;
            end
         end
         if (acc) begin
            r = make_rec(bif.min_x, bif.min_y, bif.min_z, bif.max_x, bif.max_y, bif.max_z);
            fifo_q.push_back(r);
            for (int k = 0; k < 12; k++) stream_q.push_back(r[k]);
         end
         m_run = 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (bp_mode) bif.byte_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_box(input logic [15:0] a, b, c, d, e, g);
      int   n = 0;
      logic acc = 1'b0;
      bif.min_x = a; bif.min_y = b; bif.min_z = c;
      bif.max_x = d; bif.max_y = e; bif.max_z = g;
      bif.valid_in = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bif.ready_out;
         step();
         n++;
      end
      bif.valid_in = 1'b0;
      chk("accept_timeout", acc, 1);
   endtask

   task automatic send_rand();
      send_box(16'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (bif.busy && n < max_cyc) begin
         step();
         n++;
      end
      chk("drain_timeout", n < max_cyc, 1);
   endtask

   task automatic clear_capture();
      got_q.delete();
      stream_q.delete();
   endtask

   task automatic check_stream(input string name);
      int bad = 0;
      chk({name, "_len"}, got_q.size(), stream_q.size());
      for (int j = 0; j < got_q.size() && j < stream_q.size(); j++)
         if (got_q[j][7:0] !== stream_q[j]) bad++;
      chk({name, "_data"}, bad, 0);
   endtask

   vec_t vec [4];

   initial begin
      logic [95:0] cap;
      logic [35:0] lmask;
      int          nlast, lastpos, n;
      logic [15:0] cnt0;

      vec[0] = '{16'h0100, 16'hFF80, 16'h0000, 16'h0A00, 16'h0080, 16'h1234,
                 96'h1234_0080_0A00_0000_FF80_0100};
      vec[1] = '{16'h7FFF, 16'h8000, 16'h00FF, 16'hFF00, 16'h5A5A, 16'hA5A5,
                 96'hA5A5_5A5A_FF00_00FF_8000_7FFF};
      vec[2] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC,
                 96'hBBCC_99AA_7788_5566_3344_1122};
      vec[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};

      rst = 1'b1;
      bif.valid_in = 1'b0; bif.byte_ready = 1'b0;
      bif.min_x = '0; bif.min_y = '0; bif.min_z = '0;
      bif.max_x = '0; bif.max_y = '0; bif.max_z = '0;
      bp_mode = 0; dut_acc = 0; run_len = 0; max_run = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_out", bif.ready_out, 0);
      chk("rst_byte_valid", bif.byte_valid, 0);
      chk("rst_busy", bif.busy, 0);
      chk("rst_byte_last", bif.byte_last, 0);
      chk("rst_box_count", bif.box_count, 0);
      chk("rst_byte_out", bif.byte_out, 0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", bif.ready_out, 1);

      // directed vectors with latency check
      bif.byte_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         clear_capture();
         send_box(vec[i].min_x, vec[i].min_y, vec[i].min_z,
                  vec[i].max_x, vec[i].max_y, vec[i].max_z);
         chk("lat_edge_e", bif.byte_valid, 0);
         step();
         chk("lat_edge_e1", bif.byte_valid, 1);
         chk("lat_byte0", bif.byte_out, vec[i].exp_bytes[7:0]);
         wait_idle(100);
         chk("vec_len", got_q.size(), 12);
         cap = '0; nlast = 0; lastpos = -1;
         for (int j = 0; j < got_q.size() && j < 12; j++) begin
            cap[8*j +: 8] = got_q[j][7:0];
            if (got_q[j][8]) begin
               nlast++;
               lastpos = j;
            end
         end
         chk("vec_bytes", cap, vec[i].exp_bytes);
         chk("vec_last_cnt", nlast, 1);
         chk("vec_last_pos", lastpos, 11);
         chk("vec_count", bif.box_count, i + 1);
      end

      // back-to-back: 36 byte cycles with no gap
      clear_capture();
      cnt0 = m_count; max_run = 0;
      repeat (3) send_rand();
      wait_idle(200);
      chk("b2b_run", max_run, 36);
      lmask = '0;
      for (int j = 0; j < got_q.size() && j < 36; j++) lmask[j] = got_q[j][8];
      chk("b2b_last_mask", lmask, 36'h8_0080_0800);
      chk("b2b_count", bif.box_count, cnt0 + 16'd3);
      check_stream("b2b");

      // random backpressure
      clear_capture();
      bp_mode = 1;
      repeat (6) send_rand();
      wait_idle(2000);
      bp_mode = 0;
      check_stream("bp");

      // full FIFO: byte_ready low, valid_in held high
      clear_capture();
      bif.byte_ready = 1'b0;
      dut_acc = 0;
      bif.valid_in = 1'b1;
      repeat (12) begin
         bif.min_x = 16'($urandom); bif.min_y = 16'($urandom); bif.min_z = 16'($urandom);
         bif.max_x = 16'($urandom); bif.max_y = 16'($urandom); bif.max_z = 16'($urandom);
         step();
      end
      chk("full_accepted", dut_acc, DEPTH + 1);
      chk("full_ready_low", bif.ready_out, 0);
      bif.valid_in = 1'b0;
      bif.byte_ready = 1'b1;
      wait_idle(300);
      chk("full_bytes", got_q.size(), 12 * (DEPTH + 1));
      check_stream("full");

      // reset mid-box at byte index 5 with two boxes queued
      clear_capture();
      repeat (3) send_rand();
      n = 0;
      while (got_q.size() < 5 && n < 100) begin
         step();
         n++;
      end
      chk("midrst_reach_idx5", got_q.size(), 5);
      rst = 1'b1;
      bif.byte_ready = 1'b0;
      step();
      rst = 1'b0;
      chk("midrst_byte_valid", bif.byte_valid, 0);
      chk("midrst_busy", bif.busy, 0);
      chk("midrst_box_count", bif.box_count, 0);
      chk("midrst_byte_last", bif.byte_last, 0);
      chk("midrst_byte_out", bif.byte_out, 0);
      step();
      chk("midrst_ready", bif.ready_out, 1);
      bif.byte_ready = 1'b1;
      send_box(vec[1].min_x, vec[1].min_y, vec[1].min_z,
               vec[1].max_x, vec[1].max_y, vec[1].max_z);
      wait_idle(100);
      chk("postrst_first", (got_q.size() > 0) ? got_q[0][7:0] : 8'hxx, 8'hFF);
      chk("postrst_count", bif.box_count, 1);
      check_stream("postrst");

      // random traffic with random gaps and backpressure
      clear_capture();
      bp_mode = 1;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) step();
         send_rand();
      end
      wait_idle(3000);
      bp_mode = 0;
      check_stream("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/bbox_byte_serializer.md
BBOX_BYTE_SERIALIZER -- requirements
Module: bbox_byte_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning box FIFO depth in entries; legal values are 2, 4, 8 and 16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 valid_in  input  1  upstream box valid.
REQ-005 ready_out  output  1  block can accept a box this cycle.
REQ-006 min_x, min_y, min_z, max_x, max_y, max_z  input  16 each, signed s7.8  box fields; sampled on acceptance.
REQ-007 byte_out  output  8  serialized byte.
REQ-008 byte_valid  output  1  byte_out valid.
REQ-009 byte_ready  input  1  downstream accepts the byte.
REQ-010 byte_last  output  1  high with the 12th byte of a box.
REQ-011 busy  output  1  FIFO non-empty or a box is in transmission.
REQ-012 box_count  output  16  number of boxes fully transmitted, modulo 2^16.

Function
REQ-013 Acceptance SHALL occur on an edge where valid_in=1 and ready_out=1; the six fields SHALL be written bit-exact as one 96-bit FIFO entry.
REQ-014 ready_out SHALL be 1 exactly when FIFO occupancy < DEPTH; it SHALL be a function of registered state only, with no combinational path from byte_ready or valid_in.
REQ-015 A pop in the same cycle SHALL NOT free a slot for a push; when the FIFO is full, ready_out stays 0 that cycle.
REQ-016 The serializer FSM SHALL have two states, IDLE and SEND.
REQ-017 IDLE->SEND SHALL occur at the first edge where the FIFO is non-empty; at that edge the head entry is popped into a holding register, the byte index is set to 0 and byte_valid is set to 1.
REQ-018 Byte order SHALL be index 0..11: min_x[7:0], min_x[15:8], min_y lo, min_y hi, min_z lo, min_z hi, max_x lo, max_x hi, max_y lo, max_y hi, max_z lo, max_z hi. This is the little-endian 12-byte record format of the offline test files.
REQ-019 In SEND, byte_out SHALL equal the byte selected by the current index; byte_out and byte_last SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-020 A byte handshake (byte_valid and byte_ready both 1) SHALL advance the index by 1.
REQ-021 byte_last SHALL be 1 exactly when byte_valid=1 and index=11.
REQ-022 On the handshake of index 11, box_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-023 On that same index-11 handshake, if the FIFO is non-empty the next entry SHALL be popped at that edge and index reset to 0 with byte_valid kept 1 (zero-bubble). Otherwise the FSM SHALL go to IDLE with byte_valid=0.
REQ-024 Latency: a box accepted at edge E into an empty FIFO with the FSM in IDLE SHALL present byte 0 with byte_valid=1 immediately after edge E+1.
REQ-025 busy SHALL be (state==SEND) or (occupancy != 0), derived from registered state.
REQ-026 The block SHALL NOT inspect, reorder, sign-extend or range-check field values.

Reset
REQ-027 While rst=1 at an edge, the block SHALL clear FIFO pointers and occupancy, set the FSM to IDLE, and set byte_index=0, byte_valid=0, byte_out=0x00, box_count=0. While rst is asserted, ready_out=0, busy=0 and byte_last=0.
REQ-028 ready_out SHALL be 1 after the first edge with rst=0.
REQ-029 Reset mid-box SHALL discard the partial box and all queued boxes, with no byte_last emitted and no box_count increment.

Verification
REQ-030 Single box min=(0x0100,0xFF80,0x0000), max=(0x0A00,0x0080,0x1234), byte_ready=1 -> bytes 00 01 80 FF 00 00 00 0A 80 00 34 12; byte_valid rises immediately after edge E+1; byte_last on 0x12 only; box_count=1.
REQ-031 Back-to-back: 3 boxes, byte_ready=1 -> 36 consecutive byte_valid cycles with no gap; byte_last on bytes 12, 24 and 36; box_count=3.
REQ-032 Backpressure: byte_ready toggles randomly -> byte_out and byte_last stable during stalls; stream equals the no-stall stream.
REQ-033 Full: DEPTH=4, byte_ready=0, valid_in=1 constantly -> FSM holds 1 box, FIFO accepts 4 more, then ready_out=0; no acceptance while full; the 5 boxes later emerge in order.
REQ-034 rst asserted at byte index 5 with 2 boxes queued -> next cycle byte_valid=0, busy=0, box_count=0; a new box afterwards starts at byte 0.
REQ-035 Wrap: box_count preloaded via 65535 boxes, then one more -> box_count=0x0000.
